if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch_if.sv | 21 ++
 rtl/if_prefetch.sv | 114 +++++++++++
 tb/tb_if_prefetch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction memory (slave). Requests use valid/ready; responses are in order.
interface if_prefetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/if_prefetch.sv
// Instruction fetch with a DEPTH-entry prefetch buffer and ID redirect support.
// Optional feature: define IF_PERF_CNT_EN to add the bubble_cnt output.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_flag_id,
    input  logic [XLEN-1:0]  jump_address_id,
    if_prefetch_if.master    imem,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  instruction,
    output logic [XLEN-1:0]  instruction_address
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]      bubble_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            not_empty, req_fire, push, pop;

    assign not_empty = (count != '0);
    assign req_fire  = imem.imem_req_valid & imem.imem_req_ready;
    // A redirect kills both the response and the pop happening in its cycle.
    assign push      = (state == S_WAIT) & imem.imem_rsp_valid & ~jump_flag_id;
    assign pop       = not_empty & if_ready & ~jump_flag_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: if (req_fire) state_next = jump_flag_id ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (imem.imem_rsp_valid)  state_next = S_IDLE;
                else if (jump_flag_id)    state_next = S_DROP;
            end
            S_DROP: if (imem.imem_rsp_valid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req_valid = ~rst & (state == S_IDLE) & (count < CW'(DEPTH));
        imem.imem_req_addr  = fetch_pc;
        if_valid            = not_empty;
        instruction         = not_empty ? instr_mem[rd_ptr] : NOP;
        instruction_address = not_empty ? pc_mem[rd_ptr]    : fetch_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            if (req_fire) req_pc <= fetch_pc;
            if (jump_flag_id)  fetch_pc <= jump_address_id;
            else if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump_flag_id) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage has no reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= req_pc;
            instr_mem[wr_ptr] <= imem.imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           bubble_cnt <= '0;
        else if (if_ready && !not_empty && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: a queue-based program-order model with
// redirect epochs, plus a behavioural single-outstanding instruction memory.
module tb_if_prefetch;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_id;
    logic [31:0] jump_address_id;
    logic        if_valid, if_ready;
    logic [31:0] instruction, instruction_address;
`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    if_prefetch_if #(.XLEN(XLEN)) bus ();

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .jump_flag_id        (jump_flag_id),
        .jump_address_id     (jump_address_id),
        .imem                (bus.master),
        .if_valid            (if_valid),
        .if_ready            (if_ready),
        .instruction         (instruction),
        .instruction_address (instruction_address)
`ifdef IF_PERF_CNT_EN
        ,
        .bubble_cnt          (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    entry_t      q[$];
    logic [31:0] m_pc;
    int          epoch = 0;
    bit          pending = 0;
    logic [31:0] pend_addr;
    int          pend_epoch;
    int          pend_wait;
    int          lat = 0;
    bit          stray = 0;
    int          fire_cnt = 0;
    logic [31:0] bubbles = 0;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs against the model, advance the model.
    task automatic step(bit jmp, logic [31:0] jaddr, bit rready, bit iready);
        bit exp_rv, rsp, fire, pop;
        int ep0;
        @(negedge clk);
`ifdef IF_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, bubbles);
`endif
        rsp                 = pending && pend_wait == 0;
        jump_flag_id        = jmp;
        jump_address_id     = jaddr;
        bus.imem_req_ready  = rready;
        if_ready            = iready;
        bus.imem_rsp_valid  = rsp || stray;
        bus.imem_rsp_data   = rsp ? mem_data(pend_addr) : $urandom;
        #1;
        exp_rv = !pending && q.size() < DEPTH;
        check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", bus.imem_req_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("instr_addr", instruction_address, q[0].pc);
            check("instr", instruction, q[0].instr);
        end else begin
            check("empty_instr", instruction, NOP);
            check("empty_addr", instruction_address, m_pc);
        end
        fire = exp_rv && rready;
        pop  = q.size() != 0 && iready && !jmp;
        if (iready && q.size() == 0 && bubbles != 32'hFFFF_FFFF) bubbles++;
        ep0 = epoch;
        if (pop) void'(q.pop_front());
        if (rsp) begin
            pending = 0;
            if (!jmp && pend_epoch == epoch) q.push_back('{pend_addr, mem_data(pend_addr)});
        end else if (pending) begin
            pend_wait--;
        end
        if (jmp) begin
            q.delete();
            epoch++;
        end
        if (fire) begin
            pending    = 1;
            pend_addr  = m_pc;
            pend_epoch = ep0;
            pend_wait  = lat;
            fire_cnt++;
        end
        m_pc = jmp ? jaddr : (fire ? m_pc + 32'd4 : m_pc);
    endtask

    // Asserts rst between clock edges and checks the outputs react without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst                = 1'b1;
        jump_flag_id       = 1'b0;
        jump_address_id    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if_ready           = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_instr", instruction, NOP);
        check("rst_instr_addr", instruction_address, RESET_PC);
`ifdef IF_PERF_CNT_EN
        check("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        pending = 0;
        m_pc    = RESET_PC;
        bubbles = 0;
        epoch++;
    endtask

    initial begin
        rst = 1'b1;
        jump_flag_id = 1'b0;
        jump_address_id = '0;
        if_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        m_pc = RESET_PC;
        do_reset();

        // Streaming: always-ready memory, one-cycle response, consumer always ready.
        lat = 0;
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);

        // Stalled consumer fills the buffer, then a single pop reopens fetch.
        do_reset();
        fire_cnt = 0;
        repeat (16) step(1'b0, '0, 1'b1, 1'b0);
        check("fill_requests", fire_cnt, DEPTH);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("resume_request", fire_cnt, DEPTH + 1);

        // Redirect while a request is outstanding: stale response must vanish.
        lat = 3;
        for (int i = 0; i < 20 && !pending; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b1);
        lat = 0;
        repeat (8) step(1'b0, '0, 1'b1, 1'b1);

        // Redirect coinciding with a response and a pop.
        for (int i = 0; i < 20 && !(pending && pend_wait == 0 && q.size() != 0); i++)
            step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // Address wrap, entered via a redirect that coincides with a request handshake.
        step(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1);

        // Reset mid-WAIT, stray post-reset response, then idle bubbles.
        lat = 6;
        for (int i = 0; i < 20 && !pending; i++) step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        do_reset();
        stray = 1;
        step(1'b0, '0, 1'b0, 1'b0);
        stray = 0;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        lat = 0;
        step(1'b0, '0, 1'b1, 1'b1);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic with occasional redirects and resets.
        repeat (3000) begin
            logic [31:0] ja;
            lat = $urandom_range(0, 3);
            ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2))
                                               : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 99) < 4, ja, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
